// File: rtl/prog_mem_loader.sv
// Writable program memory for the accumulator CPU: a host streams program words
// in byte-by-byte while the CPU is held off, then fetches are range-checked reads.
module prog_mem_loader #(
  parameter int ADDR_BUS  = 11,
  parameter int DATA_SIZE = 16,
  parameter int BYTE_W    = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Load_En,
  input  logic [BYTE_W-1:0]    Byte_In,
  input  logic                 Byte_Valid,
  output logic                 Load_Busy,
  output logic [ADDR_BUS:0]    Prog_Len,
  output logic                 Load_Err,
  input  logic                 Rd_En,
  input  logic [ADDR_BUS-1:0]  Addr,
  output logic [DATA_SIZE-1:0] Data,
  output logic                 Data_Valid,
  output logic                 Out_Of_Range
);

  localparam int unsigned BYTES = DATA_SIZE / BYTE_W;
  localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned DEPTH = 2 ** ADDR_BUS;
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [ADDR_BUS:0] FULL_PTR  = {1'b1, {ADDR_BUS{1'b0}}};

  typedef enum logic {RUN, LOAD} state_t;

  logic [DATA_SIZE-1:0]        r_mem [DEPTH];
  state_t                      r_state;
  logic [ADDR_BUS:0]           r_wr_ptr;
  logic [CNT_W-1:0]            r_byte_cnt;
  // Only the bytes preceding the current one need storing; the last byte
  // comes straight from Byte_In in the write cycle.
  logic [DATA_SIZE-BYTE_W-1:0] r_shift;

  logic                 w_full;
  logic                 w_byte;
  logic                 w_we;
  logic                 w_in_range;
  logic [DATA_SIZE-1:0] w_word;

  always_comb begin
    w_full     = (r_wr_ptr == FULL_PTR);
    w_byte     = (r_state == LOAD) && Load_En && Byte_Valid;
    w_word     = {r_shift, Byte_In};
    w_we       = w_byte && !w_full && (r_byte_cnt == LAST_BYTE);
    w_in_range = ({1'b0, Addr} < Prog_Len);
  end

  always_ff @(posedge Clk) begin
    if (w_we) r_mem[r_wr_ptr[ADDR_BUS-1:0]] <= w_word;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= RUN;
      r_wr_ptr     <= '0;
      r_byte_cnt   <= '0;
      r_shift      <= '0;
      Prog_Len     <= '0;
      Load_Err     <= 1'b0;
      Load_Busy    <= 1'b0;
      Data         <= '0;
      Data_Valid   <= 1'b0;
      Out_Of_Range <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (Load_En) begin
            r_state    <= LOAD;
            r_wr_ptr   <= '0;
            r_byte_cnt <= '0;
            Load_Err   <= 1'b0;
            Prog_Len   <= '0;
            Load_Busy  <= 1'b1;
            Data_Valid <= 1'b0;
          end else begin
            Data_Valid <= Rd_En;
            if (Rd_En) begin
              if (w_in_range) begin
                Data         <= r_mem[Addr];
                Out_Of_Range <= 1'b0;
              end else begin
                Data         <= '0;
                Out_Of_Range <= 1'b1;
              end
            end
          end
        end
        LOAD: begin
          Data_Valid <= 1'b0;
          if (!Load_En) begin
            r_state    <= RUN;
            Load_Busy  <= 1'b0;
            Prog_Len   <= r_wr_ptr;
            r_byte_cnt <= '0;
            if (r_byte_cnt != '0) Load_Err <= 1'b1;
          end else if (Byte_Valid) begin
            if (w_full) begin
              Load_Err <= 1'b1;
            end else begin
              r_shift <= w_word[DATA_SIZE-BYTE_W-1:0];
              if (r_byte_cnt == LAST_BYTE) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_byte_cnt <= '0;
              end else begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
              end
            end
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Randomized bench for prog_mem_loader (ADDR_BUS=3) against a word-level model
// derived from the byte stream of each load.
module tb_prog_mem_loader;

  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Load_En;
  logic [7:0]  Byte_In;
  logic        Byte_Valid;
  logic        Load_Busy;
  logic [AW:0] Prog_Len;
  logic        Load_Err;
  logic        Rd_En;
  logic [AW-1:0] Addr;
  logic [15:0] Data;
  logic        Data_Valid;
  logic        Out_Of_Range;

  prog_mem_loader #(.ADDR_BUS(AW), .DATA_SIZE(16), .BYTE_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Load_En(Load_En), .Byte_In(Byte_In),
    .Byte_Valid(Byte_Valid), .Load_Busy(Load_Busy), .Prog_Len(Prog_Len),
    .Load_Err(Load_Err), .Rd_En(Rd_En), .Addr(Addr), .Data(Data),
    .Data_Valid(Data_Valid), .Out_Of_Range(Out_Of_Range)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_mem [DEPTH];
  int          m_len;
  bit          m_err;
  logic [7:0]  q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic rand_words(input int w);
    for (int i = 0; i < 2 * w; i++) q.push_back(8'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(Load_Busy), 32'd0);
    check({tag, "_len"},  32'(Prog_Len), 32'd0);
    check({tag, "_err"},  32'(Load_Err), 32'd0);
    check({tag, "_dv"},   32'(Data_Valid), 32'd0);
    check({tag, "_data"}, 32'(Data), 32'd0);
    check({tag, "_oor"},  32'(Out_Of_Range), 32'd0);
  endtask

  task automatic fetch(input int a);
    logic [15:0] e;
    bit          oor;
    oor = (a >= m_len);
    e   = oor ? 16'h0000 : m_mem[a];
    Rd_En = 1'b1;
    Addr  = AW'(a);
    cyc();
    Rd_En = 1'b0;
    check("fetch_dv",   32'(Data_Valid), 32'd1);
    check("fetch_data", 32'(Data), 32'(e));
    check("fetch_oor",  32'(Out_Of_Range), 32'(oor));
    cyc();
    check("idle_dv",   32'(Data_Valid), 32'd0);
    check("idle_hold", 32'(Data), 32'(e));
  endtask

  // Streams q as one load session; model: complete words up to DEPTH are kept,
  // any odd trailing byte or any byte beyond DEPTH words flags an error.
  task automatic do_load(input bit hold_rd);
    int n;
    int stored;
    n = q.size();
    Load_En = 1'b1;
    if (hold_rd) begin
      Rd_En = 1'b1;
      Addr  = '0;
    end
    cyc();
    check("load_busy", 32'(Load_Busy), 32'd1);
    if (hold_rd) check("load_dv", 32'(Data_Valid), 32'd0);
    foreach (q[i]) begin
      Byte_In    = q[i];
      Byte_Valid = 1'b1;
      cyc();
      Byte_Valid = 1'b0;
      check("load_busy", 32'(Load_Busy), 32'd1);
      if (hold_rd) check("load_dv", 32'(Data_Valid), 32'd0);
      repeat ($urandom_range(0, 2)) begin
        cyc();
        if (hold_rd) check("load_dv", 32'(Data_Valid), 32'd0);
      end
    end
    Load_En = 1'b0;
    cyc();
    stored = (n / 2 > DEPTH) ? DEPTH : n / 2;
    for (int i = 0; i < stored; i++) m_mem[i] = {q[2*i], q[2*i+1]};
    m_len = stored;
    m_err = (n % 2 != 0) || (n > 2 * DEPTH);
    check("done_busy", 32'(Load_Busy), 32'd0);
    check("prog_len",  32'(Prog_Len), 32'(m_len));
    check("load_err",  32'(Load_Err), 32'(m_err));
    if (hold_rd) begin
      check("exit_dv", 32'(Data_Valid), 32'd0);
      cyc();
      Rd_En = 1'b0;
      check("resume_dv",   32'(Data_Valid), 32'd1);
      check("resume_data", 32'(Data), 32'((m_len > 0) ? m_mem[0] : 16'h0000));
      cyc();
    end
  endtask

  initial begin
    Reset = 1'b1; Load_En = 1'b0; Byte_In = '0; Byte_Valid = 1'b0;
    Rd_En = 1'b0; Addr = '0;
    m_len = 0; m_err = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    cyc();

    fetch(0);

    // Bytes strobed while running must not be captured.
    for (int i = 0; i < 4; i++) begin
      Byte_In = 8'($urandom); Byte_Valid = 1'b1; cyc();
    end
    Byte_Valid = 1'b0;
    check("run_bytes_len", 32'(Prog_Len), 32'd0);

    q = '{8'h18, 8'h10, 8'h08, 8'h01, 8'h10, 8'h01, 8'h28, 8'hFF,
          8'h08, 8'h02, 8'h10, 8'h10, 8'h00, 8'h00};
    do_load(1'b0);
    for (int a = 0; a < DEPTH; a++) fetch(a);

    q.delete(); rand_words(2); q.push_back(8'hAB);
    do_load(1'b0);
    fetch(2); fetch(0); fetch(1);

    q.delete(); rand_words(5);
    do_load(1'b1);
    fetch(4); fetch(5);

    q.delete(); rand_words(9);
    do_load(1'b0);
    for (int a = 0; a < DEPTH; a++) fetch(a);

    for (int k = 0; k < 4; k++) begin
      q.delete();
      for (int i = 0; i < int'($urandom_range(0, 20)); i++) q.push_back(8'($urandom));
      do_load(k[0]);
      for (int i = 0; i < 6; i++) fetch(int'($urandom_range(0, DEPTH - 1)));
    end

    // Abort a load between the two bytes of word 3.
    q.delete(); rand_words(3); q.push_back(8'($urandom));
    Load_En = 1'b1;
    cyc();
    foreach (q[i]) begin
      Byte_In = q[i]; Byte_Valid = 1'b1; cyc();
    end
    Byte_Valid = 1'b0;
    @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    Load_En = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    m_len = 0; m_err = 1'b0;
    cyc();
    check("rst_len", 32'(Prog_Len), 32'd0);
    for (int a = 0; a < 3; a++) fetch(a);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
